fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter and issues word reads to a synchronous instruction ROM. Buffers returned 26-bit instructions in a small queue and presents them, with their PC, to the decoder under a valid/stall handshake. Accepts a branch redirect that flushes all buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the program counter and issues one word read per cycle to a synchronous
// instruction ROM. Returned instructions are buffered, with their PC, in a small
// FIFO whose head is presented to the decoder under a valid/stall handshake.
// A branch redirect flushes every buffered and in-flight instruction.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   stall_i             decoder cannot accept the head this cycle
//   redirect_i          one-cycle branch-taken pulse, refetch from redirect_pc_i
//   redirect_pc_i       redirect target word address
//   imem_en_o           ROM read enable (combinational)
//   imem_addr_o         ROM word address (equals the PC register)
//   imem_rdata_i        ROM data, valid one cycle after an enabled cycle
//   inst_valid_o        queue head holds an instruction
//   inst_o, pc_o        queue head instruction and its PC; zero when empty
module fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [25:0]       imem_rdata_i,
  output logic              inst_valid_o,
  output logic [25:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int CNT_W = 3;
  localparam int OCC_W = 4;
  localparam int ENT_W = ADDR_W + 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ret_pc_q, ret_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [ENT_W-1:0]   queue_q [DEPTH];
  logic [ENT_W-1:0]   queue_d [DEPTH];

  logic               valid_s;
  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic [OCC_W-1:0]   occ_s;
  logic [CNT_W-1:0]   wr_idx_s;

  // Handshake terms: outputs are forced idle while reset is asserted so no
  // stale entry is ever visible during the reset cycle.
  always_comb begin
    valid_s  = rst_n & (count_q != {CNT_W{1'b0}});
    pop_s    = valid_s & ~stall_i & ~redirect_i;
    push_s   = inflight_q & ~redirect_i;
    // Occupancy after this cycle's pop, counting the read already in flight;
    // issuing only while it is below DEPTH keeps the FIFO from overflowing.
    occ_s    = {1'b0, count_q} + {{(OCC_W-1){1'b0}}, inflight_q}
             - {{(OCC_W-1){1'b0}}, pop_s};
    issue_s  = rst_n & (state_q == ST_RUN) & ~redirect_i & (occ_s < OCC_W'(DEPTH));
    // A pop shifts the FIFO down, so the free slot moves down with it.
    wr_idx_s = count_q - {{(CNT_W-1){1'b0}}, pop_s};
  end

  // Next-state, PC, in-flight tracking and FIFO update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ret_pc_d   = ret_pc_q;
    count_d    = count_q;
    inflight_d = 1'b0;
    queue_d    = queue_q;

    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (redirect_i) begin
      // Redirect wins over everything: drop the FIFO and the in-flight return.
      state_d    = ST_FLUSH;
      pc_d       = redirect_pc_i;
      count_d    = {CNT_W{1'b0}};
      inflight_d = 1'b0;
    end else begin
      if (issue_s) begin
        pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        ret_pc_d   = pc_q;
        inflight_d = 1'b1;
      end else begin
        inflight_d = 1'b0;
      end

      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          queue_d[i] = queue_q[i+1];
        end
        queue_d[DEPTH-1] = {ENT_W{1'b0}};
      end else begin
        queue_d = queue_d;
      end

      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx_s) begin
            queue_d[i] = {ret_pc_q, imem_rdata_i};
          end else begin
            queue_d[i] = queue_d[i];
          end
        end
      end else begin
        queue_d = queue_d;
      end

      count_d = count_q + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      ret_pc_q   <= {ADDR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      inflight_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        queue_q[i] <= {ENT_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_pc_q   <= ret_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < DEPTH; i++) begin
        queue_q[i] <= queue_d[i];
      end
    end
  end

  // Output drive: head of the FIFO, zeroed when empty.
  always_comb begin
    imem_en_o    = issue_s;
    imem_addr_o  = pc_q;
    inst_valid_o = valid_s;
    if (valid_s) begin
      inst_o = queue_q[0][25:0];
      pc_o   = queue_q[0][ENT_W-1:26];
    end else begin
      inst_o = 26'd0;
      pc_o   = {ADDR_W{1'b0}};
    end
  end

  fetch_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_i    (count_q),
    .inflight_i (inflight_q)
  );

endmodule

// fetch_unit_chk: occupancy invariant for fetch_unit (FIFO never overflows).
// Ports: clk, rst_n, count_i (FIFO entries), inflight_i (outstanding ROM read).
module fetch_unit_chk #(
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic [2:0] count_i,
  input logic       inflight_i
);

  // Entries plus the outstanding read must always fit in the FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count_i} + {3'b000, inflight_i}) <= 4'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A ROM model returns addr+0x100.
// Stimulus pushes the expected {pc, inst} stream into a scoreboard queue;
// a monitor compares the FIFO head whenever the DUT presents an instruction.
// A second instance with ADDR_W=4, RESET_PC=14 exercises PC wrap.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [25:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        imem_en_o;
  logic [15:0] imem_addr_o;
  logic [25:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [25:0] inst_o;
  logic [15:0] pc_o;

  logic        en4;
  logic [3:0]  addr4;
  logic [25:0] rdata4;
  logic        valid4;
  logic [25:0] inst4;
  logic [3:0]  pc4;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  exp_t exp4_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_en_o(imem_en_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  fetch_unit #(.ADDR_W(4), .RESET_PC(14), .DEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(4'd0), .imem_en_o(en4), .imem_addr_o(addr4),
    .imem_rdata_i(rdata4), .inst_valid_o(valid4), .inst_o(inst4), .pc_o(pc4)
  );

  // Synchronous ROMs: ROM[a] = a + 0x100.
  always @(posedge clk) begin
    if (imem_en_o) imem_rdata_i <= 26'(imem_addr_o) + 26'h100;
    if (en4)       rdata4       <= 26'(addr4) + 26'h100;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = 26'(pc) + 26'h100;
    return e;
  endfunction

  task automatic push_range(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 16'(i)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect inst_valid_o low for three cycles then high (pipeline refill).
  task automatic refill_check(input string name);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(name, {31'd0, inst_valid_o}, {31'd0, (k == 3)});
      if (k == 0) chk({name, "_en_bubble"}, {31'd0, imem_en_o}, 32'd0);
      if (k == 1) chk({name, "_en_issue"}, {31'd0, imem_en_o}, 32'd1);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({name, "_inst"},  {6'd0, inst_o}, 32'd0);
    chk({name, "_pc"},    {16'd0, pc_o}, 32'd0);
    chk({name, "_en"},    {31'd0, imem_en_o}, 32'd0);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n && !redirect_i) begin
      if (inst_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst_pc", {16'd0, pc_o}, 32'hFFFF_FFFF);
        end else begin
          chk("head_pc",   {16'd0, pc_o}, {16'd0, exp_q[0].pc});
          chk("head_inst", {6'd0, inst_o}, {6'd0, exp_q[0].inst});
          if (!stall_i) void'(exp_q.pop_front());
        end
      end else begin
        chk("empty_pc",   {16'd0, pc_o}, 32'd0);
        chk("empty_inst", {6'd0, inst_o}, 32'd0);
      end
    end
  end

  // Monitor for the narrow wrap instance.
  always @(negedge clk) begin
    if (rst_n && valid4 && exp4_q.size() > 0) begin
      chk("wrap_pc",   {28'd0, pc4}, {16'd0, exp4_q[0].pc});
      chk("wrap_inst", {6'd0, inst4}, {6'd0, exp4_q[0].inst});
      void'(exp4_q.pop_front());
    end
  end

  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 16'd0;
    foreach (exp4_q[i]) exp4_q.delete();
    exp4_q.push_back(mk(16'd14));
    exp4_q.push_back(mk(16'd15));
    exp4_q.push_back(mk(16'd0));
    exp4_q.push_back(mk(16'd1));
    exp4_q.push_back(mk(16'd2));

    repeat (3) step();
    check_reset_outputs("reset");
    push_range(16'd0, 64);
    step();
    rst_n = 1'b1;
    refill_check("lat_reset");
    repeat (8) step();

    // Stall while streaming: head held, fetch stops once the FIFO is full.
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_en",    {31'd0, imem_en_o}, 32'd0);
      chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      step();
    end
    stall_i = 1'b0;
    repeat (6) step();

    // Redirect with a full FIFO; stall is ignored in the redirect cycle.
    stall_i = 1'b1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h0040;
    exp_q.delete();
    push_range(16'h0040, 32);
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    refill_check("lat_redirect");
    repeat (5) step();

    // Back-to-back redirects: only the second target may emerge.
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h0010;
    exp_q.delete();
    step();
    redirect_pc_i = 16'h0020;
    push_range(16'h0020, 32);
    step();
    redirect_i = 1'b0;
    refill_check("lat_b2b");
    repeat (5) step();

    // One-cycle reset mid-stream with a read in flight.
    rst_n = 1'b0;
    exp_q.delete();
    check_reset_outputs("midreset");
    push_range(16'd0, 32);
    step();
    rst_n = 1'b1;
    refill_check("lat_midreset");
    repeat (5) step();

    @(negedge clk);
    chk("wrap_all_seen", exp4_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
